alu_arbiter: RTL

Time-multiplexes the single ALU, with its 3-bit ALU opcode and NZCV flag path, between two requesters: requester 0 is the instruction datapath and requester 1 is an auxiliary engine such as an address or multiply helper. Each requester is accepted through a valid/ready handshake and its operation is issued to the ALU for one cycle. The result is returned on a registered response channel, and the architectural CPSR flags are updated only for operations that request it.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU arbiter
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_ORR    = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_NOT    = 3'b101,
        ALU_PASS_A = 3'b110,
        ALU_PASS_B = 3'b111
    } alu_op_t;

    // Bit positions inside the {N,Z,C,V} flag nibble.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way requester pick; ALU_ARB_FIXED_PRIO_EN selects fixed priority
import alu_pkg::*;

module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            case (valid)
                2'b01: grant = 2'b01;
                2'b10: grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11: grant = 2'b01;
`else
                // On a tie the requester that did not win last time goes first.
                2'b11: grant = last_grant ? 2'b01 : 2'b10;
`endif
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; ALU_ARB_FIXED_PRIO_EN selects fixed priority
import alu_pkg::*;

module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_flags,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_set_flags,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       cpsr
);

    arb_state_t       state_q;
    alu_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             set_flags_q, set_flags_d;
    logic             id_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       cpsr_q;
    logic             last_grant;
    logic             accept_window;
    logic [1:0]       grant;
    logic             accept;
    logic             pick;

    // A new op may enter only when nothing is in flight and any held response is leaving.
    assign accept_window = !reset &&
                           ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    logic last_grant_q;
    assign last_grant = last_grant_q;
`endif

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .advance    (accept_window),
        .grant      (grant)
    );

    assign accept      = |grant;
    assign pick        = grant[1];
    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];

    assign op_d        = pick ? alu_op_t'(req1_op) : alu_op_t'(req0_op);
    assign a_d         = pick ? req1_a : req0_a;
    assign b_d         = pick ? req1_b : req0_b;
    assign set_flags_d = pick ? req1_set_flags : req0_set_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= ALU_ADD;
            a_q          <= '0;
            b_q          <= '0;
            set_flags_q  <= 1'b0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            cpsr_q       <= 4'b0000;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            if (accept) begin
                op_q        <= op_d;
                a_q         <= a_d;
                b_q         <= b_d;
                set_flags_q <= set_flags_d;
                id_q        <= pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last_grant_q <= pick;
`endif
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= ISSUE;
                end
                ISSUE: begin
                    rsp_result_q <= alu_result;
                    rsp_id_q     <= id_q;
                    if (set_flags_q) cpsr_q <= alu_flags;
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state_q <= accept ? ISSUE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ALU inputs always come from the latch so they stay quiet between ops.
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign cpsr       = cpsr_q;

endmodule
